// File: rtl/issue_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// issue_arbiter_pkg
// Shared compute-unit types for the dispatch -> operand collector path.
// Holds the default compute-unit configuration, the scalar types used on the
// issue path (tag_t, reg_idx_t, warp_id_t), the issue payload struct and a
// small round-robin pointer helper.
// No ports (package).
// -----------------------------------------------------------------------------
package issue_arbiter_pkg;

    localparam int unsigned CuNumWarps        = 8;
    localparam int unsigned CuNumTags         = 8;
    localparam int unsigned CuRegIdxWidth     = 6;
    localparam int unsigned CuOperandsPerInst = 2;

    // Width helpers stay at least one bit wide so single-warp or
    // single-tag configurations still elaborate.
    localparam int unsigned CuTagWidth    = (CuNumTags  > 1) ? $clog2(CuNumTags)  : 1;
    localparam int unsigned CuWarpIdWidth = (CuNumWarps > 1) ? $clog2(CuNumWarps) : 1;

    typedef logic [CuTagWidth-1:0]    tag_t;
    typedef logic [CuRegIdxWidth-1:0] reg_idx_t;
    typedef logic [CuWarpIdWidth-1:0] warp_id_t;

    // Operand k occupies bits [k*CuRegIdxWidth +: CuRegIdxWidth].
    typedef struct packed {
        tag_t                                        tag;
        reg_idx_t                                    dst;
        logic [CuOperandsPerInst*CuRegIdxWidth-1:0]  operands;
    } issue_payload_t;

    // Pointer to the warp after idx, wrapping at n (n need not be a power
    // of two, so a plain increment-and-truncate is not enough).
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/issue_rr_arb.sv
// -----------------------------------------------------------------------------
// issue_rr_arb
// Purely combinational round-robin pick: the lowest requesting index at or
// above the pointer wins; if none, the lowest requesting index overall.
// Ports:
//   valid      in   NumWarps   request vector
//   ptr        in   PtrWidth   round-robin start index (always < NumWarps)
//   grant      out  NumWarps   one-hot winner, zero when no request
//   idx        out  PtrWidth   binary winner index (0 when no request)
//   any_valid  out  1          at least one request present
// -----------------------------------------------------------------------------
module issue_rr_arb #(
    parameter int unsigned NumWarps = 8,
    parameter int unsigned PtrWidth = 3
) (
    input  logic [NumWarps-1:0] valid,
    input  logic [PtrWidth-1:0] ptr,
    output logic [NumWarps-1:0] grant,
    output logic [PtrWidth-1:0] idx,
    output logic                any_valid
);

    logic [PtrWidth-1:0] idx_hi;
    logic [PtrWidth-1:0] idx_lo;
    logic                found_hi;

    // Scanning downward lets the last hit be the lowest index; idx_lo tracks
    // the overall lowest request, idx_hi the lowest one at or above ptr.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        for (int i = int'(NumWarps) - 1; i >= 0; i--) begin
            if (valid[i]) begin
                idx_lo = PtrWidth'(i);
                if (i >= int'(ptr)) begin
                    idx_hi   = PtrWidth'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    always_comb begin
        any_valid = |valid;
        idx       = found_hi ? idx_hi : idx_lo;
        grant     = '0;
        if (any_valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/issue_arbiter.sv
// -----------------------------------------------------------------------------
// issue_arbiter
// Round-robin arbiter letting NumWarps per-warp dispatchers share a single
// operand collector through a one-entry output register.
// Ports:
//   clk_i            in   1                              clock
//   rst_ni           in   1                              async active-low reset
//   disp_valid_i     in   NumWarps                       per-warp request
//   disp_ready_o     out  NumWarps                       per-warp accept (one-hot)
//   disp_tag_i       in   NumWarps*TagWidth              per-warp tag
//   disp_dst_i       in   NumWarps*RegIdxWidth           per-warp destination
//   disp_operands_i  in   NumWarps*OperandsPerInst*RegIdxWidth  sources
//   opc_ready_i      in   1                              collector can accept
//   opc_valid_o      out  1                              issued instruction valid
//   opc_warp_id_o    out  WarpIdWidth                    issuing warp
//   opc_tag_o / opc_dst_o / opc_operands_o  out          registered payload
//
// Handshake: on both sides a transfer happens on a rising edge where valid
// and ready are both high. A dispatcher's ready is granted only from the
// request vector, the round-robin pointer and the load condition, never from
// payload. Once opc_valid_o is up, it and the payload hold until a cycle
// with opc_ready_i high.
// -----------------------------------------------------------------------------
module issue_arbiter
    import issue_arbiter_pkg::*;
#(
    parameter  int unsigned NumWarps        = CuNumWarps,
    parameter  int unsigned NumTags         = CuNumTags,
    parameter  int unsigned RegIdxWidth     = CuRegIdxWidth,
    parameter  int unsigned OperandsPerInst = CuOperandsPerInst,
    localparam int unsigned TagWidth        = (NumTags  > 1) ? $clog2(NumTags)  : 1,
    localparam int unsigned WarpIdWidth     = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    localparam int unsigned OpsWidth        = OperandsPerInst * RegIdxWidth
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumWarps-1:0]          disp_valid_i,
    output logic [NumWarps-1:0]          disp_ready_o,
    input  logic [NumWarps*TagWidth-1:0] disp_tag_i,
    input  logic [NumWarps*RegIdxWidth-1:0] disp_dst_i,
    input  logic [NumWarps*OpsWidth-1:0] disp_operands_i,
    input  logic                         opc_ready_i,
    output logic                         opc_valid_o,
    output logic [WarpIdWidth-1:0]       opc_warp_id_o,
    output logic [TagWidth-1:0]          opc_tag_o,
    output logic [RegIdxWidth-1:0]       opc_dst_o,
    output logic [OpsWidth-1:0]          opc_operands_o
);

    logic [NumWarps-1:0]    grant;
    logic [WarpIdWidth-1:0] win_idx;
    logic                   any_valid;
    logic [WarpIdWidth-1:0] rr_ptr;
    logic                   load;

    logic                   opc_valid_q;
    warp_id_t               warp_q;
    issue_payload_t         payload_q;
    issue_payload_t         win_payload;

    issue_rr_arb #(
        .NumWarps (NumWarps),
        .PtrWidth (WarpIdWidth)
    ) u_rr_arb (
        .valid     (disp_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // The register may load when empty or when its content drains this
    // cycle, which allows back-to-back issue.
    assign load = !opc_valid_q || opc_ready_i;

    // Gating with rst_ni keeps any accept from being signalled while the
    // register is held in reset.
    assign disp_ready_o = (load && rst_ni) ? grant : '0;

    always_comb begin
        win_payload          = '0;
        win_payload.tag      = disp_tag_i[int'(win_idx)*TagWidth +: TagWidth];
        win_payload.dst      = disp_dst_i[int'(win_idx)*RegIdxWidth +: RegIdxWidth];
        win_payload.operands = disp_operands_i[int'(win_idx)*OpsWidth +: OpsWidth];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opc_valid_q <= 1'b0;
            warp_q      <= '0;
            payload_q   <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            opc_valid_q <= any_valid;
            if (any_valid) begin
                warp_q    <= win_idx;
                payload_q <= win_payload;
                rr_ptr    <= WarpIdWidth'(rr_next(int'(win_idx), NumWarps));
            end
        end
    end

    assign opc_valid_o    = opc_valid_q;
    assign opc_warp_id_o  = warp_q;
    assign opc_tag_o      = payload_q.tag;
    assign opc_dst_o      = payload_q.dst;
    assign opc_operands_o = payload_q.operands;

endmodule

// File: tb/tb_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_issue_arbiter
// Self-checking bench for issue_arbiter at its default configuration.
// A behavioural model tracks the output register and the round-robin start
// point as plain integers; the winner is found by walking warps in circular
// order from that start point. A scoreboard queue records every accepted
// instruction and is popped on every collector handshake.
// -----------------------------------------------------------------------------
module tb_issue_arbiter;

    localparam int N   = 8;
    localparam int TW  = 3;
    localparam int RW  = 6;
    localparam int OPS = 2;
    localparam int OW  = OPS * RW;
    localparam int EW  = 3 + TW + RW + OW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0]    disp_valid = '0;
    logic [N-1:0]    disp_ready;
    logic [N*TW-1:0] disp_tag = '0;
    logic [N*RW-1:0] disp_dst = '0;
    logic [N*OW-1:0] disp_ops = '0;
    logic            opc_ready = 1'b0;
    logic            opc_valid;
    logic [2:0]      opc_warp;
    logic [TW-1:0]   opc_tag;
    logic [RW-1:0]   opc_dst;
    logic [OW-1:0]   opc_ops;

    issue_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .disp_valid_i    (disp_valid),
        .disp_ready_o    (disp_ready),
        .disp_tag_i      (disp_tag),
        .disp_dst_i      (disp_dst),
        .disp_operands_i (disp_ops),
        .opc_ready_i     (opc_ready),
        .opc_valid_o     (opc_valid),
        .opc_warp_id_o   (opc_warp),
        .opc_tag_o       (opc_tag),
        .opc_dst_o       (opc_dst),
        .opc_operands_o  (opc_ops)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_ptr;
    bit            m_valid;
    int            m_warp;
    logic [TW-1:0] m_tag;
    logic [RW-1:0] m_dst;
    logic [OW-1:0] m_ops;
    int            wait_cnt[N];
    logic [EW-1:0] exp_q[$];
    int            issued_q[$];

    // Values seen at the last sampling point, for directed checks.
    logic [N-1:0]  last_rdy;
    logic          last_valid;
    logic [2:0]    last_warp;
    logic [TW-1:0] last_tag;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_warp  = 0;
        m_tag   = '0;
        m_dst   = '0;
        m_ops   = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // One clock: compare at the falling edge, advance the model at the rising
    // edge, return 1 time unit later so the caller can drive the next inputs.
    task automatic cycle();
        int            w;
        bit            ld;
        logic [N-1:0]  exp_rdy;
        logic [EW-1:0] ent;
        @(negedge clk);
        ld      = !m_valid || opc_ready;
        w       = (rst_n && ld) ? pick(disp_valid, m_ptr) : -1;
        exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
        last_rdy   = disp_ready;
        last_valid = opc_valid;
        last_warp  = opc_warp;
        last_tag   = opc_tag;
        check("disp_ready", disp_ready, exp_rdy);
        check("opc_valid", opc_valid, m_valid);
        if (m_valid) begin
            check("opc_warp", opc_warp, m_warp);
            check("opc_tag", opc_tag, m_tag);
            check("opc_dst", opc_dst, m_dst);
            check("opc_ops", opc_ops, m_ops);
        end
        if (rst_n && opc_valid && opc_ready) begin
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                check("sb_entry", {opc_warp, opc_tag, opc_dst, opc_ops}, ent);
            end
            issued_q.push_back(int'(opc_warp));
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (ld) begin
            if (w >= 0) begin
                m_valid = 1;
                m_warp  = w;
                m_tag   = disp_tag[w*TW +: TW];
                m_dst   = disp_dst[w*RW +: RW];
                m_ops   = disp_ops[w*OW +: OW];
                m_ptr   = (w + 1) % N;
                exp_q.push_back({3'(w), m_tag, m_dst, m_ops});
                for (int v = 0; v < N; v++) begin
                    if (v == w) begin
                        wait_cnt[v] = 0;
                    end else if (disp_valid[v]) begin
                        wait_cnt[v]++;
                        check("no_starve", wait_cnt[v] < N, 1);
                    end else begin
                        wait_cnt[v] = 0;
                    end
                end
            end else begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_opc_valid", opc_valid, 0);
        check("rst_opc_warp", opc_warp, 0);
        check("rst_opc_tag", opc_tag, 0);
        check("rst_opc_dst", opc_dst, 0);
        check("rst_opc_ops", opc_ops, 0);
        check("rst_disp_ready", disp_ready, 0);
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_warp(input int w, input logic [TW-1:0] t, input logic [RW-1:0] d);
        disp_tag[w*TW +: TW] = t;
        disp_dst[w*RW +: RW] = d;
        disp_ops[w*OW +: OW] = OW'($urandom);
    endtask

    task automatic rand_payload();
        disp_tag = N*TW'($urandom);
        disp_dst = {16'($urandom), 32'($urandom)};
        disp_ops = {32'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #2;

        // Reset with every warp requesting: nothing may be accepted.
        disp_valid = '1;
        do_reset();

        // Single request from warp 2 with tag 3.
        opc_ready  = 1'b1;
        disp_valid = 8'b0000_0100;
        set_warp(2, 3'd3, 6'd17);
        cycle();
        check("single_ready", last_rdy, 8'b0000_0100);
        disp_valid = '0;
        cycle();
        check("single_valid", last_valid, 1);
        check("single_warp", last_warp, 2);
        check("single_tag", last_tag, 3);

        // All warps requesting from a fresh pointer: strict rotation.
        do_reset();
        rand_payload();
        disp_valid = '1;
        opc_ready  = 1'b1;
        issued_q.delete();
        repeat (11) cycle();
        check("rr_order_len", issued_q.size() >= 10, 1);
        for (int i = 0; i < 10 && i < issued_q.size(); i++) begin
            check("rr_order", issued_q[i], i % N);
        end

        // Wrap-around: pointer at 6, only warps 0 and 1 request.
        disp_valid = '0;
        do_reset();
        disp_valid = 8'b0010_0000;
        cycle();
        disp_valid = 8'b0000_0011;
        cycle();
        check("wrap_win0", last_rdy, 8'b0000_0001);
        cycle();
        check("wrap_ptr1", last_rdy, 8'b0000_0010);

        // Backpressure: warp 5 held for 3 cycles, then drain and refill.
        disp_valid = '0;
        do_reset();
        opc_ready  = 1'b0;
        disp_valid = 8'b0010_0000;
        set_warp(5, 3'd6, 6'd9);
        cycle();
        set_warp(5, 3'd1, 6'd40);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_ready", last_rdy, 0);
            check("stall_valid", last_valid, 1);
            check("stall_warp", last_warp, 5);
            check("stall_tag", last_tag, 6);
        end
        opc_ready = 1'b1;
        cycle();
        check("refill_ready", last_rdy, 8'b0010_0000);
        disp_valid = '0;
        cycle();
        check("refill_valid", last_valid, 1);
        check("refill_warp", last_warp, 5);
        check("refill_tag", last_tag, 1);

        // Reset while an instruction is held undelivered.
        opc_ready  = 1'b0;
        disp_valid = 8'b0000_1000;
        cycle();
        cycle();
        do_reset();
        disp_valid = '1;
        opc_ready  = 1'b1;
        cycle();
        check("post_rst_ptr0", last_rdy, 8'b0000_0001);

        // Random stress with a reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            rand_payload();
            disp_valid = N'($urandom);
            opc_ready  = ($urandom_range(0, 9) < 7);
            if (i == 1500) do_reset();
            else cycle();
        end

        // Drain and make sure every accepted instruction came out.
        disp_valid = '0;
        opc_ready  = 1'b1;
        repeat (3) cycle();
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_arbiter.md
ISSUE_ARBITER -- requirements
Module: issue_arbiter

Interface
REQ-001 SHALL have parameter NumWarps, default 8: number of per-warp dispatchers sharing one operand collector.
REQ-002 SHALL have parameter NumTags, default 8: inflight tags per warp; TagWidth = $clog2(NumTags).
REQ-003 SHALL have parameter RegIdxWidth, default 6: register index width.
REQ-004 SHALL have parameter OperandsPerInst, default 2: source operands per instruction.
REQ-005 SHALL have port clk_i  input  1  the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port disp_valid_i  input  NumWarps  per-warp dispatch request.
REQ-008 SHALL have port disp_ready_o  output  NumWarps  per-warp grant/accept.
REQ-009 SHALL have port disp_tag_i  input  NumWarps x TagWidth  per-warp tag.
REQ-010 SHALL have port disp_dst_i  input  NumWarps x RegIdxWidth  per-warp destination register.
REQ-011 SHALL have port disp_operands_i  input  NumWarps x OperandsPerInst x RegIdxWidth  per-warp source registers.
REQ-012 SHALL have port opc_ready_i  input  1  operand collector can accept.
REQ-013 SHALL have port opc_valid_o  output  1  issued instruction valid.
REQ-014 SHALL have port opc_warp_id_o  output  $clog2(NumWarps)  warp of the issued instruction.
REQ-015 SHALL have ports opc_tag_o, opc_dst_o, opc_operands_o  output  TagWidth, RegIdxWidth, OperandsPerInst x RegIdxWidth  registered payload.

Function
REQ-016 SHALL hold a single-entry output register (valid bit + warp id + payload); opc_* outputs drive directly from it.
REQ-017 SHALL treat the register as able to load when !opc_valid_o or opc_ready_i (drain and refill in the same cycle allowed).
REQ-018 SHALL, when able to load and any disp_valid_i set, assert disp_ready_o for exactly one warp (the winner) and zero for all others; otherwise disp_ready_o = 0.
REQ-019 SHALL select the winner round-robin: lowest index w >= rr_ptr with disp_valid_i[w], else lowest index overall (wrap-around).
REQ-020 SHALL, on an accept (disp_valid_i[w] && disp_ready_o[w]), capture w and its payload next edge and set rr_ptr = (w+1) mod NumWarps; rr_ptr unchanged otherwise.
REQ-021 SHALL give one-cycle latency from accept to opc_valid_o; no combinational path disp_* -> opc_*.
REQ-022 SHALL keep opc_valid_o and payload stable while opc_valid_o && !opc_ready_i.
REQ-023 SHALL clear opc_valid_o after opc_ready_i handshake when no new accept occurs that cycle.
REQ-024 SHALL sustain one issue per cycle when opc_ready_i held high and requests present.
REQ-025 SHALL not make disp_ready_o depend on disp_valid_i of the winner only through payload; grant derives from valid vector, rr_ptr, and load condition only.
REQ-026 SHALL, for NumWarps not a power of two, wrap rr_ptr at NumWarps, never reaching an out-of-range index.

Reset
REQ-027 SHALL on rst_ni low: opc_valid_o = 0, rr_ptr = 0, opc_warp_id_o/tag/dst/operands = 0, disp_ready_o = 0 combinationally derived (no accept possible in reset).
REQ-028 SHALL discard a held, undelivered instruction on reset mid-operation.

Structure
REQ-029 SHALL place warp_id_t and issue payload struct (tag, dst, operands) in the shared compute-unit package with the existing tag_t/reg_idx_t.
REQ-030 SHALL implement the round-robin pick as one sub-module issue_rr_arb (valid vector + pointer in, one-hot grant + index out); register stage stays in issue_arbiter.

Verification
REQ-031 SHALL cover: reset, opc_ready_i=1, disp_valid_i=8'b0000_0100 tag 3 -> disp_ready_o=8'b0000_0100, next cycle opc_valid_o=1, warp_id=2, tag=3.
REQ-032 SHALL cover: all 8 valid, opc_ready_i=1 for 10 cycles -> issue order 0,1,...,7,0,1.
REQ-033 SHALL cover: rr_ptr=6, valid=8'b0000_0011 -> warp 0 wins, rr_ptr becomes 1.
REQ-034 SHALL cover: opc_valid_o=1, opc_ready_i=0 for 3 cycles with warp 5 requesting -> disp_ready_o=0, payload unchanged; on opc_ready_i=1 warp 5 accepted same cycle, issued next.
REQ-035 SHALL cover: rst_ni low while opc_valid_o=1 -> opc_valid_o=0 immediately, rr_ptr=0; random stress with scoreboard: every accepted instruction issued exactly once, in acceptance order, no starvation within NumWarps issues.
